// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer regfile write port (EXU vs LSU) with a registered write stage
// and a per-register pending-write scoreboard. Define WB_ARB_RR_EN for round-robin contention handling.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_exu_valid,
  output logic            o_exu_ready,
  input  logic [AW-1:0]   i_exu_rd,
  input  logic [XLEN-1:0] i_exu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [AW-1:0]   i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rd,
  input  logic [AW-1:0]   i_chk_rs,
  output logic            o_chk_busy,
  output logic            o_en_regw,
  output logic [AW-1:0]   o_rd,
  output logic [XLEN-1:0] o_data_write
);

  logic            w_exu_win;
  logic            w_lsu_win;
  logic            w_accept;
  logic            w_commit;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [NREG-1:0] w_busy;

  logic            r_en_regw;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_data_write;

`ifdef WB_ARB_RR_EN
  // Set when the most recent contended grant went to LSU; reset value points at EXU.
  logic r_last_lsu;

  always_comb begin
    w_lsu_win = i_lsu_valid && (!i_exu_valid || !r_last_lsu);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_lsu <= 1'b0;
    end else if (i_exu_valid && i_lsu_valid) begin
      r_last_lsu <= w_lsu_win;
    end
  end
`else
  always_comb begin
    w_lsu_win = i_lsu_valid;
  end
`endif

  always_comb begin
    w_exu_win  = i_exu_valid && !w_lsu_win;
    w_accept   = w_exu_win || w_lsu_win;
    w_sel_rd   = w_lsu_win ? i_lsu_rd : i_exu_rd;
    w_sel_data = w_lsu_win ? i_lsu_data : i_exu_data;
    // Writes to x0 are accepted but never reach the regfile.
    w_commit   = w_accept && (w_sel_rd != '0);
  end

  assign o_exu_ready = w_exu_win;
  assign o_lsu_ready = w_lsu_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en_regw    <= 1'b0;
      r_rd         <= '0;
      r_data_write <= '0;
    end else begin
      r_en_regw <= w_commit;
      if (w_commit) begin
        r_rd         <= w_sel_rd;
        r_data_write <= w_sel_data;
      end
    end
  end

  assign o_en_regw    = r_en_regw;
  assign o_rd         = r_rd;
  assign o_data_write = r_data_write;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_busy[gi] = 1'b0;
      end else begin : g_reg
        logic r_busy;
        logic w_set;
        logic w_clr;

        assign w_set = i_issue_valid && (i_issue_rd == AW'(gi));
        assign w_clr = r_en_regw && (r_rd == AW'(gi));

        // A new issue on the clearing edge wins: a younger writer is now pending.
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_busy <= 1'b0;
          end else if (w_set) begin
            r_busy <= 1'b1;
          end else if (w_clr) begin
            r_busy <= 1'b0;
          end
        end

        assign w_busy[gi] = r_busy;
      end
    end
  endgenerate

  assign o_chk_busy = w_busy[i_chk_rs];

endmodule
